uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter, successor to the fixed 8N1 transmitter.
//  Internal baud divider, runtime parity (none/even/odd) and 1/2 stop bits.
//  Small write FIFO so the host can queue several words; frames go out back-to-back.
//  Sits between the host write port and the serial line. Its tx output drives the receiver.
// PARAMETERS
//  DATA_BITS     8   data bits per frame, legal 5..9
//  CLKS_PER_BIT  16  clk cycles per serial bit, >=2
//  FIFO_DEPTH    4   FIFO entries, power of 2, >=2
// PORTS
//  clk          in   1                      system clock, rising edge
//  rst_n        in   1                      async active-low reset
//  din          in   DATA_BITS              word to queue
//  wr_en        in   1                      write strobe, accepted only when full==0
//  parity_mode  in   2                      00 none, 01 even, 10 odd, 11 treated as none
//  two_stop     in   1                      1 = two stop bits, 0 = one
//  tx           out  1                      serial line, idles high
//  tx_busy      out  1                      high while a frame is on the line
//  full         out  1                      FIFO holds FIFO_DEPTH entries
//  fifo_count   out  $clog2(FIFO_DEPTH)+1   entries currently queued
//  overflow     out  1                      1-cycle pulse when wr_en arrives while full (word dropped)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - tx=1, tx_busy=0, full=0, fifo_count=0, overflow=0.
//   - FSM returns to IDLE. FIFO pointers and the baud counter are cleared.
//   - A frame in progress is abandoned and is not resumed.
//  Write: on a clk edge with wr_en=1 && full=0, din is stored at the tail.
//   - The write is visible in fifo_count after that edge.
//   - full is the registered pre-edge value. A pop in the same cycle does not make room for that write.
//  FSM states: IDLE, START, DATA, PARITY, STOP. Every non-IDLE bit lasts exactly CLKS_PER_BIT cycles.
//  IDLE: tx=1, tx_busy=0.
//   - If fifo_count!=0, the next edge pops the head into the shift register and enters START.
//   - parity_mode and two_stop are latched on that same edge.
//   - Latency: a word written at edge N into an empty FIFO while IDLE gives tx=0 after edge N+1.
//  START: tx=0. Then DATA.
//  DATA: DATA_BITS bits, LSB first. After the last bit, go to PARITY if the latched mode is even/odd, else STOP.
//  PARITY: tx = XOR of data bits (even), or its inverse (odd).
//  STOP: tx=1 for 1 or 2 bit times (latched two_stop).
//   - At the end of the final stop-bit cycle: if fifo_count!=0, pop and go straight to START with no idle cycle.
//   - Otherwise go to IDLE.
//  Frame length = (1 + DATA_BITS + P + S) * CLKS_PER_BIT cycles, with P in {0,1} and S in {1,2}.
//  tx_busy=1 in START/DATA/PARITY/STOP, including across back-to-back frames.
//  Input changes to parity_mode/two_stop mid-frame affect only the next frame.
//  fifo_count: +1 on accepted write, -1 on pop, unchanged when both happen in the same cycle.
//  Pointers wrap modulo FIFO_DEPTH.
//  tx is driven from a register; no combinational path from any input to tx.
// TESTING (DATA_BITS=8, CLKS_PER_BIT=16, FIFO_DEPTH=4)
//  1. Hold rst_n=0 -> tx=1, tx_busy=0, full=0, fifo_count=0, overflow=0. Release -> still idle.
//  2. Write 8'h63, parity 00, two_stop 0.
//     -> tx=0 for 16 cycles, then 1,1,0,0,0,1,1,0 at 16 cycles each, then 1.
//     -> tx_busy high for exactly 160 cycles.
//  3. 8'h63 with parity 01 -> parity bit 0. With 10 -> parity bit 1.
//     With two_stop=1 and parity 01 -> tx_busy high for 192 cycles.
//  4. While idle, write 6 words on consecutive cycles.
//     -> word 1 is popped, words 2-5 fill the FIFO (full=1), word 6 is dropped with a 1-cycle overflow pulse.
//     -> 5 frames are sent with no gap, and tx_busy never drops between them.
//  5. Assert rst_n low during data bit 3 -> tx=1 and tx_busy=0 immediately, with no clk edge.
//     After release, fifo_count=0 and no further frames are sent.
//  6. Switch parity_mode 00->10 during the DATA state -> the current frame has no parity bit.
//     A queued next frame carries an odd parity bit.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO, internal baud divider, runtime
// parity (none/even/odd) and one or two stop bits; frames are sent back-to-back.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          wr_en,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [2:0]                    dbg_state_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  two_stop_q, two_stop_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];

  logic push, pop, bit_done;

  assign full        = (count_q == DEPTH_C);
  assign push        = wr_en && !full;
  assign bit_done    = (baud_q == BAUD_LAST);
  assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
  assign tx          = tx_q;
  assign tx_busy     = (state_q != S_IDLE);
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    pop        = 1'b0;
    tx_d       = 1'b1;

    if (state_q != S_IDLE) begin
      baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            stop2_d = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          stop2_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (two_stop_q && !stop2_q) stop2_d = 1'b1;
          else if (count_q != '0)     pop     = 1'b1;
          else                        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop loads the next frame and latches its line settings.
    if (pop) begin
      state_d    = S_START;
      baud_d     = '0;
      shift_d    = mem_q[rd_ptr_q];
      data_d     = mem_q[rd_ptr_q];
      par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
      par_odd_d  = (parity_mode == 2'b10);
      two_stop_d = two_stop;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = (^data_q) ^ par_odd_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      ovf_q      <= wr_en && full;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a serial-line monitor decodes every frame
// against a queue of expected {two_stop, parity_mode, data} entries.
module tb_uart_tx_fifo;
  localparam int DW  = 8;
  localparam int CPB = 16;
  localparam int FD  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic [1:0]    parity_mode = 2'b00;
  logic          two_stop = 1'b0;
  logic          tx, tx_busy, full, overflow;
  logic [2:0]    fifo_count;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW+2:0] exp_q[$];

  uart_tx_fifo #(.DATA_BITS(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en),
    .parity_mode(parity_mode), .two_stop(two_stop),
    .tx(tx), .tx_busy(tx_busy), .full(full), .fifo_count(fifo_count),
    .overflow(overflow), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one write strobe for one edge; optionally queue the expected frame.
  task automatic put(input logic [DW-1:0] d, input logic [1:0] pm, input logic ts, input bit keep);
    din   = d;
    wr_en = 1'b1;
    if (keep) exp_q.push_back({ts, pm, d});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic measure_busy(output int n);
    int w;
    w = 0;
    n = 0;
    while (tx_busy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    while (tx_busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Serial monitor: samples mid-bit on falling clk edges.
  bit            mon_act = 1'b0;
  int            mon_cnt, mon_last, mon_k;
  logic          mon_pen;
  logic [DW+2:0] mon_cur;
  logic [DW-1:0] mon_rx;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        chk("mon_frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_cur  = exp_q[0];
          mon_pen  = (mon_cur[DW+1:DW] == 2'b01) || (mon_cur[DW+1:DW] == 2'b10);
          mon_last = DW + 1 + int'(mon_pen) + int'(mon_cur[DW+2]);
          mon_cnt  = 0;
          mon_rx   = '0;
          mon_act  = 1'b1;
        end
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % CPB == CPB / 2) begin
        mon_k = mon_cnt / CPB;
        if (mon_k == 0)
          chk("mon_start", 32'(tx), 32'd0);
        else if (mon_k <= DW)
          mon_rx[mon_k-1] = tx;
        else if (mon_pen && mon_k == DW + 1)
          chk("mon_parity", 32'(tx), 32'((^mon_cur[DW-1:0]) ^ (mon_cur[DW+1:DW] == 2'b10)));
        else
          chk("mon_stop", 32'(tx), 32'd1);
        if (mon_k == mon_last) begin
          chk("mon_data", 32'(mon_rx), 32'(mon_cur[DW-1:0]));
          void'(exp_q.pop_front());
          mon_act = 1'b0;
        end
      end
    end
  end

  initial begin
    int            n;
    bit            any_low;
    logic [DW-1:0] w63;
    logic [DW-1:0] burst [6];
    int            cnt_exp [6];
    logic          bit_exp;

    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(tx_busy), 32'd0);
    chk("idle_count", 32'(fifo_count), 32'd0);

    // 8N1 frame of 0x63, checked cycle by cycle.
    w63 = 8'h63;
    parity_mode = 2'b00;
    two_stop = 1'b0;
    put(w63, 2'b00, 1'b0, 1'b1);
    chk("t2_count_after_write", 32'(fifo_count), 32'd1);
    chk("t2_tx_before_start", 32'(tx), 32'd1);
    for (int j = 0; j < 10; j++) begin
      bit_exp = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : w63[j-1];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk($sformatf("t2_tx_bit%0d_c%0d", j, c), 32'(tx), 32'(bit_exp));
        chk("t2_busy", 32'(tx_busy), 32'd1);
      end
    end
    @(negedge clk);
    chk("t2_busy_end", 32'(tx_busy), 32'd0);
    chk("t2_tx_end", 32'(tx), 32'd1);
    chk("t2_queue_drained", 32'(exp_q.size()), 32'd0);

    // Parity variants and two stop bits.
    parity_mode = 2'b01;
    put(w63, 2'b01, 1'b0, 1'b1);
    measure_busy(n);
    chk("t3_even_busy", 32'(n), 32'd176);
    parity_mode = 2'b10;
    put(w63, 2'b10, 1'b0, 1'b1);
    measure_busy(n);
    chk("t3_odd_busy", 32'(n), 32'd176);
    parity_mode = 2'b01;
    two_stop = 1'b1;
    put(w63, 2'b01, 1'b1, 1'b1);
    measure_busy(n);
    chk("t3_even_2stop_busy", 32'(n), 32'd192);
    chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // Burst of six writes: one popped, four queued, one dropped.
    parity_mode = 2'b00;
    two_stop = 1'b0;
    burst   = '{8'h11, 8'hA7, 8'h3C, 8'hF0, 8'h5B, 8'hEE};
    cnt_exp = '{1, 1, 2, 3, 4, 4};
    for (int i = 0; i < 6; i++) begin
      din   = burst[i];
      wr_en = 1'b1;
      if (i < 5) exp_q.push_back({1'b0, 2'b00, burst[i]});
      @(negedge clk);
      chk($sformatf("t4_count_w%0d", i), 32'(fifo_count), 32'(cnt_exp[i]));
      chk($sformatf("t4_full_w%0d", i), 32'(full), 32'(i >= 4));
      chk($sformatf("t4_overflow_w%0d", i), 32'(overflow), 32'(i == 5));
    end
    wr_en = 1'b0;
    @(negedge clk);
    chk("t4_overflow_pulse_end", 32'(overflow), 32'd0);
    chk("t4_count_hold", 32'(fifo_count), 32'd4);
    measure_busy(n);
    chk("t4_busy_run", 32'(n), 32'd795);
    chk("t4_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_count_end", 32'(fifo_count), 32'd0);

    // Asynchronous reset during data bit 3 abandons the frame and the queue.
    put(8'hA5, 2'b00, 1'b0, 1'b1);
    put(8'h3C, 2'b00, 1'b0, 1'b1);
    repeat (70) @(negedge clk);
    chk("t5_pre_tx_bit3", 32'(tx), 32'd0);
    chk("t5_pre_busy", 32'(tx_busy), 32'd1);
    chk("t5_pre_count", 32'(fifo_count), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_tx", 32'(tx), 32'd1);
    chk("t5_async_busy", 32'(tx_busy), 32'd0);
    chk("t5_async_count", 32'(fifo_count), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    any_low = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) any_low = 1'b1;
    end
    chk("t5_line_quiet", 32'(any_low), 32'd0);
    chk("t5_count_after", 32'(fifo_count), 32'd0);

    // Parity change mid-frame applies only to the queued frame.
    parity_mode = 2'b00;
    put(8'h62, 2'b00, 1'b0, 1'b1);
    put(8'h5A, 2'b10, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    chk("t6_in_data", 32'(dbg_state), 32'd2);
    parity_mode = 2'b10;
    measure_busy(n);
    chk("t6_busy_run", 32'(n), 32'd296);
    chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("t6_tx_idle", 32'(tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
